mux_scan_n: RTL and testbench
=============================

MUX_SCAN_N -- requirements
Module: mux_scan_n

Interface
REQ-001 Parameter WIDTH, default 8: data bits per channel; legal range 1..64.
REQ-002 Parameter CH, default 4: number of input channels; legal range 2..16; need not be a power of two.
REQ-003 Parameter DWELL, default 4: cycles spent on each channel in auto-scan mode; legal range 1..256.
REQ-004 Derived SELW = $clog2(CH): select width, not user-set.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 en  input  1  block enable; low freezes all state.
REQ-009 mode  input  1  0 = manual select; 1 = auto round-robin scan.
REQ-010 sel_in  input  SELW  manual channel select.
REQ-011 d  input  CH*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-012 y  output  WIDTH  registered selected data.
REQ-013 y_valid  output  1  y holds data sampled on the previous edge.
REQ-014 sel_out  output  SELW  channel that produced the current y.
REQ-015 wrap  output  1  one-cycle pulse when the scan moves from channel CH-1 to channel 0.
REQ-016 err  output  1  one-cycle pulse on an out-of-range manual select.

Function
REQ-017 FSM states: IDLE, MAN, SCAN; all outputs are registered.
REQ-018 Transitions: any state with en=0 -> IDLE; en=1 and mode=0 -> MAN; en=1 and mode=1 -> SCAN; all evaluated every edge.
REQ-019 Latency: y, sel_out and y_valid update on the edge after d and the select are sampled (1 cycle).
REQ-020 IDLE:
- y and sel_out hold their values.
- y_valid = 0; wrap = 0; err = 0.
- Dwell counter holds.
REQ-021 MAN with sel_in < CH:
- y <= d[sel_in]; sel_out <= sel_in; y_valid <= 1.
- Dwell counter cleared to 0.
REQ-022 MAN with sel_in >= CH (non-power-of-two CH only):
- y and sel_out hold.
- y_valid <= 0; err pulses 1 for that cycle.
REQ-023 SCAN, every cycle: y <= d[current channel]; sel_out <= current channel; y_valid <= 1.
REQ-024 SCAN dwell counter counts 0..DWELL-1; when it is DWELL-1, the channel advances by 1 and the counter returns to 0.
REQ-025 SCAN channel advance from CH-1 goes to 0, and wrap pulses in the same cycle that sel_out first shows 0.
REQ-026 When DWELL = 1, the channel advances every cycle.
REQ-027 MAN -> SCAN entry: scan starts at the current sel_out with the counter at 0; no wrap pulse on entry.
REQ-028 SCAN -> MAN: the sel_in rules apply on the first MAN edge; the scan position is discarded.
REQ-029 IDLE -> SCAN resume: continues from the held channel and counter value.
REQ-030 Data change on d mid-dwell is reflected in y on the next edge; y is not latched for the whole dwell.

Reset
REQ-031 On rst=1 at a clock edge: state = IDLE; y = 0; sel_out = 0; y_valid = 0; wrap = 0; err = 0; dwell counter = 0.
REQ-032 rst has priority over en, mode and sel_in.
REQ-033 Reset mid-scan or mid-manual aborts immediately; the first post-reset SCAN begins at channel 0 with the counter at 0.

Verification
REQ-034 Manual sweep (WIDTH=8, CH=4, d={8'hDD,8'hCC,8'hBB,8'hAA}, mode=0, en=1): sel_in=0,1,2,3 on successive cycles -> y=AA,BB,CC,DD one cycle later; y_valid=1; err=0.
REQ-035 Auto scan (DWELL=3, CH=4, from reset):
- sel_out sequence is 0,0,0,1,1,1,2,2,2,3,3,3,0.
- wrap = 1 only on the cycle sel_out returns to 0.
REQ-036 Out-of-range select (CH=5, SELW=3, y previously 8'h11 from channel 1): sel_in=6 -> err pulses one cycle; y_valid=0; y stays 8'h11; sel_out stays 1.
REQ-037 Enable freeze (SCAN, sel_out=2, counter=1): en=0 for 5 cycles -> y_valid=0, outputs frozen; en=1 -> channel 2 held for the remaining DWELL-1 counts, then advances.
REQ-038 Reset mid-scan (sel_out=3): rst=1 for one cycle with mode=1 and en=1 held -> all outputs 0; the next SCAN cycles show sel_out=0 for a full DWELL.
REQ-039 Mode switch (MAN with sel_in=2, then mode=1): scan starts at channel 2, dwells DWELL cycles, then goes to channel 3 and wraps to 0 with a wrap pulse.

Source files
------------

// File: rtl/mux_scan_n.sv
// mux_scan_n: registered CH-way channel mux with manual select and auto round-robin scan.
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   en                  : block enable, low freezes all state
//   mode                : 0 manual select, 1 auto scan
//   sel_in              : manual channel select
//   d                   : packed channel data, channel k at [k*WIDTH +: WIDTH]
//   y, y_valid, sel_out : registered selected data, valid flag and source channel
//   wrap, err           : scan wrap pulse, out-of-range manual select pulse
module mux_scan_n #(
  parameter int WIDTH = 8,
  parameter int CH = 4,
  parameter int DWELL = 4,
  localparam int SELW = $clog2(CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [SELW-1:0]     sel_in,
  input  logic [CH*WIDTH-1:0] d,
  output logic [WIDTH-1:0]    y,
  output logic                y_valid,
  output logic [SELW-1:0]     sel_out,
  output logic                wrap,
  output logic                err
);
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
  typedef enum logic [1:0] {IDLE, MAN, SCAN} state_t;
  state_t state_q, state_d;
  logic [SELW-1:0] chan, cur, nxt;
  logic [CW-1:0] cnt;
  logic ok, last;
  // A scan entered straight from manual starts at the channel last shown,
  // even if an out-of-range select left chan behind a scan-advanced position.
  always_comb begin
    state_d = !en ? IDLE : mode ? SCAN : MAN;
    cur = (state_q == MAN) ? sel_out : chan;
    ok = int'(sel_in) < CH;
    last = cnt == CW'(DWELL - 1);
    nxt = (int'(cur) == CH - 1) ? '0 : cur + SELW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      y <= '0;
      y_valid <= 1'b0;
      sel_out <= '0;
      wrap <= 1'b0;
      err <= 1'b0;
      chan <= '0;
      cnt <= '0;
    end else begin
      state_q <= state_d;
      y_valid <= 1'b0;
      wrap <= 1'b0;
      err <= 1'b0;
      if (state_d == MAN) begin
        cnt <= '0;
        if (ok) begin
          y <= d[int'(sel_in)*WIDTH +: WIDTH];
          sel_out <= sel_in;
          chan <= sel_in;
          y_valid <= 1'b1;
        end else begin
          chan <= sel_out;
          err <= 1'b1;
        end
      end else if (state_d == SCAN) begin
        y <= d[int'(cur)*WIDTH +: WIDTH];
        sel_out <= cur;
        y_valid <= 1'b1;
        // chan reaches 0 one edge before sel_out shows it; flag the edge that shows it.
        wrap <= cur == '0 && int'(sel_out) == CH - 1;
        cnt <= last ? '0 : cnt + CW'(1);
        chan <= last ? nxt : cur;
      end
    end
  end
endmodule

// File: tb/tb_mux_scan_n.sv
// tb_mux_scan_n: directed table-driven bench for mux_scan_n (CH=4/DWELL=3 and CH=5/DWELL=2 instances).
module tb_mux_scan_n;
  typedef struct {
    logic r, e, m;
    logic [1:0] s;
    logic [7:0] y;
    logic v;
    logic [1:0] so;
    logic w, er;
  } vec_t;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, en, mode;
  logic [1:0] sel_in;
  logic [31:0] d;
  logic [7:0] y;
  logic y_valid, wrap, err;
  logic [1:0] sel_out;
  logic rst1, en1, mode1;
  logic [2:0] sel_in1;
  logic [39:0] d1;
  logic [7:0] y1;
  logic y_valid1, wrap1, err1;
  logic [2:0] sel_out1;
  int checks = 0, errors = 0;
  vec_t tbl[$];
  mux_scan_n #(.WIDTH(8), .CH(4), .DWELL(3)) u0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in), .d(d),
    .y(y), .y_valid(y_valid), .sel_out(sel_out), .wrap(wrap), .err(err)
  );
  mux_scan_n #(.WIDTH(8), .CH(5), .DWELL(2)) u1 (
    .clk(clk), .rst(rst1), .en(en1), .mode(mode1), .sel_in(sel_in1), .d(d1),
    .y(y1), .y_valid(y_valid1), .sel_out(sel_out1), .wrap(wrap1), .err(err1)
  );
  function automatic vec_t v(logic r, e, m, logic [1:0] s, logic [7:0] yy, logic vv, logic [1:0] so, logic w, er);
    vec_t t;
    t.r = r; t.e = e; t.m = m; t.s = s; t.y = yy; t.v = vv; t.so = so; t.w = w; t.er = er;
    return t;
  endfunction
  function automatic logic [7:0] cv(int c);
    return 8'(8'hAA + 8'h11 * c);
  endfunction
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk0(input string n, input logic [7:0] ey, input logic ev, input logic [1:0] es, input logic ew, input logic ee);
    chk({n, ".y"}, 64'(y), 64'(ey));
    chk({n, ".y_valid"}, 64'(y_valid), 64'(ev));
    chk({n, ".sel_out"}, 64'(sel_out), 64'(es));
    chk({n, ".wrap"}, 64'(wrap), 64'(ew));
    chk({n, ".err"}, 64'(err), 64'(ee));
  endtask
  task automatic chk1(input string n, input logic [7:0] ey, input logic ev, input logic [2:0] es, input logic ee);
    chk({n, ".y"}, 64'(y1), 64'(ey));
    chk({n, ".y_valid"}, 64'(y_valid1), 64'(ev));
    chk({n, ".sel_out"}, 64'(sel_out1), 64'(es));
    chk({n, ".wrap"}, 64'(wrap1), 64'(0));
    chk({n, ".err"}, 64'(err1), 64'(ee));
  endtask
  initial begin
    rst = 1; en = 0; mode = 0; sel_in = 0; d = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    rst1 = 1; en1 = 0; mode1 = 0; sel_in1 = 0; d1 = {8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
    tbl.push_back(v(1, 0, 0, 0, 8'h00, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++) tbl.push_back(v(0, 1, 0, 2'(k), cv(k), 1, 2'(k), 0, 0));
    tbl.push_back(v(1, 1, 1, 0, 8'h00, 0, 0, 0, 0));
    for (int k = 0; k < 12; k++) tbl.push_back(v(0, 1, 1, 0, cv(k / 3), 1, 2'(k / 3), 0, 0));
    tbl.push_back(v(0, 1, 1, 0, cv(0), 1, 0, 1, 0));
    tbl.push_back(v(0, 1, 1, 0, cv(0), 1, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, cv(0), 1, 0, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(v(0, 1, 1, 0, cv(1), 1, 1, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, cv(2), 1, 2, 0, 0));
    for (int k = 0; k < 5; k++) tbl.push_back(v(0, 0, 1, 0, cv(2), 0, 2, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, cv(2), 1, 2, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, cv(2), 1, 2, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, cv(3), 1, 3, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, cv(3), 1, 3, 0, 0));
    tbl.push_back(v(1, 1, 1, 0, 8'h00, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(v(0, 1, 1, 0, cv(0), 1, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, cv(1), 1, 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 2, cv(2), 1, 2, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(v(0, 1, 1, 0, cv(2), 1, 2, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(v(0, 1, 1, 0, cv(3), 1, 3, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, cv(0), 1, 0, 1, 0));
    tbl.push_back(v(0, 1, 1, 0, cv(0), 1, 0, 0, 0));
    #2;
    foreach (tbl[i]) begin
      rst = tbl[i].r; en = tbl[i].e; mode = tbl[i].m; sel_in = tbl[i].s;
      step();
      chk0($sformatf("row%0d", i), tbl[i].y, tbl[i].v, tbl[i].so, tbl[i].w, tbl[i].er);
    end
    d[7:0] = 8'h5A;
    step();
    chk0("mid_dwell_change", 8'h5A, 1, 0, 0, 0);
    step();
    chk0("advance_after_change", cv(1), 1, 1, 0, 0);
    step();
    chk1("u1_reset", 8'h00, 0, 0, 0);
    rst1 = 0; en1 = 1; sel_in1 = 1;
    step();
    chk1("u1_sel1", 8'h11, 1, 1, 0);
    sel_in1 = 6;
    step();
    chk1("u1_sel6_err", 8'h11, 0, 1, 1);
    sel_in1 = 4;
    step();
    chk1("u1_sel4", 8'h44, 1, 4, 0);
    sel_in1 = 5;
    step();
    chk1("u1_sel5_err", 8'h44, 0, 4, 1);
    mode1 = 1;
    step();
    chk1("u1_scan_entry", 8'h44, 1, 4, 0);
    step();
    chk1("u1_scan_dwell", 8'h44, 1, 4, 0);
    step();
    chk({"u1_wrap.sel_out"}, 64'(sel_out1), 64'(0));
    chk({"u1_wrap.wrap"}, 64'(wrap1), 64'(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
